// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO-to-stream read adapter.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned PREFETCH_DEPTH = 2;

endpackage : fifo_rd_pkg

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order prefetch buffer. The head entry always sits in r_head,
// so the stream data output is a plain register.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;

  // Shift-style update: a pop moves tail to head; a push fills the first free slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever survives the pop.
          if (r_count == 2'(PREFETCH_DEPTH)) begin
            r_head <= r_tail;
            r_tail <= i_data;
          end else begin
            r_head <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_count;

endmodule : fifo_rd_skid

// File: rtl/fifo_rd_stream.sv
// Reads words from a synchronous-read FIFO and presents them as a valid/ready
// stream through a two-entry prefetch buffer.
// Optional transfer counter (cnt_clr / word_cnt) enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

  state_t     r_state;
  logic       r_inflight;
  logic [1:0] w_count;
  logic       w_xfer;
  logic       w_pop;
  logic [2:0] w_pending;

  assign w_xfer = m_valid & m_ready;

  // Outstanding words after this edge's transfer; crediting the departing head
  // is what lets a pop issue every cycle while the buffer never exceeds two entries.
  assign w_pending = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_xfer};

  assign w_pop = enable && !fifo_empty && (r_state == RUN) &&
                 (w_pending < 3'(PREFETCH_DEPTH));

  assign fifo_rd_cs = w_pop;
  assign fifo_rd_en = w_pop;
  assign busy       = r_inflight | (w_count != 2'd0);

  // Control FSM plus the in-flight flag for the FIFO's one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
      case (r_state)
        IDLE:    if (enable) r_state <= RUN;
        RUN:     if (!enable) r_state <= DRAIN;
        DRAIN: begin
          if (enable)     r_state <= RUN;
          else if (!busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (fifo_data),
    .i_pop   (w_xfer),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_count (w_count)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] r_word_cnt;

  // Transfer counter; clear wins over a coincident transfer, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_word_cnt <= '0;
    else if (cnt_clr) r_word_cnt <= '0;
    else if (w_xfer)  r_word_cnt <= r_word_cnt + 1'b1;
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule : fifo_rd_stream

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a behavioural
// synchronous-read FIFO model on the read side.
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_rd_cs;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       busy;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic        cnt_clr;
  logic [15:0] word_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  // FIFO model: words written by the stimulus, read one cycle after fifo_rd_en.
  logic [7:0]  mem [0:63];
  int unsigned wr_cnt = 0;
  int unsigned rd_ptr = 0;
  int unsigned pop_cnt = 0;
  logic        fifo_flush = 1'b0;

  assign fifo_empty = (rd_ptr == wr_cnt);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_cnt;
    else if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
    if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
  end

  fifo_rd_stream #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_cs (fifo_rd_cs),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .word_cnt   (word_cnt)
`endif
  );

  task automatic push_word(input logic [7:0] d);
    mem[wr_cnt[5:0]] = d;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0;
`ifdef FIFO_RD_STREAM_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_rd_en !== 1'b0 || fifo_rd_cs !== 1'b0) begin fails++; $display("FAIL reset_rd got=%b%b exp=00", fifo_rd_en, fifo_rd_cs); end
    checks++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
`ifdef FIFO_RD_STREAM_CNT_EN
    checks++; if (word_cnt !== 16'd0) begin fails++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int first_pop = -1;
    int vcyc = -1;
    int vcnt = 0;
    int unsigned p0 = pop_cnt;
    push_word(8'hA5);
    m_ready = 1'b1; enable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (fifo_rd_en && first_pop < 0) first_pop = c;
      if (m_valid) begin
        vcnt++; vcyc = c;
        checks++; if (m_data !== 8'hA5) begin fails++; $display("FAIL single_data got=%h exp=a5", m_data); end
      end
      @(negedge clk);
    end
    checks++; if (pop_cnt - p0 != 1) begin fails++; $display("FAIL single_pops got=%0d exp=1", pop_cnt - p0); end
    checks++; if (vcnt != 1) begin fails++; $display("FAIL single_valid_cycles got=%0d exp=1", vcnt); end
    checks++; if (vcyc - first_pop != 2) begin fails++; $display("FAIL single_latency got=%0d exp=2", vcyc - first_pop); end
  endtask

  task automatic test_stream;
    int exp = 1;
    int bubbles = 0;
    bit started = 0;
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    for (int c = 0; c < 40 && exp <= 16; c++) begin
      #1;
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 8'(exp)) begin fails++; $display("FAIL stream_data got=%h exp=%h", m_data, 8'(exp)); end
        exp++; started = 1;
      end else if (started) bubbles++;
      @(negedge clk);
    end
    checks++; if (exp != 17) begin fails++; $display("FAIL stream_count got=%0d exp=16", exp - 1); end
    checks++; if (bubbles != 0) begin fails++; $display("FAIL stream_bubbles got=%0d exp=0", bubbles); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL stream_idle_busy got=%b exp=0", busy); end
`ifdef FIFO_RD_STREAM_CNT_EN
    checks++; if (word_cnt !== 16'd17) begin fails++; $display("FAIL stream_word_cnt got=%0d exp=17", word_cnt); end
`endif
  endtask

  task automatic test_backpressure;
    int exp = 1;
    int unsigned p0 = pop_cnt;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(8'(i));
    for (int c = 0; c < 8; c++) begin
      #1;
      if (m_valid) begin
        checks++; if (m_data !== 8'h01) begin fails++; $display("FAIL bp_hold got=%h exp=01", m_data); end
      end
      @(negedge clk);
    end
    checks++; if (pop_cnt - p0 != 2) begin fails++; $display("FAIL bp_pops got=%0d exp=2", pop_cnt - p0); end
    checks++; if (m_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got=%b exp=1", m_valid); end
    m_ready = 1'b1;
    for (int c = 0; c < 30 && exp <= 5; c++) begin
      #1;
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 8'(exp)) begin fails++; $display("FAIL bp_data got=%h exp=%h", m_data, 8'(exp)); end
        exp++;
      end
      @(negedge clk);
    end
    checks++; if (exp != 6) begin fails++; $display("FAIL bp_count got=%0d exp=5", exp - 1); end
    checks++; if (pop_cnt - p0 != 5) begin fails++; $display("FAIL bp_total_pops got=%0d exp=5", pop_cnt - p0); end
  endtask

  task automatic test_empty;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({fifo_rd_en, m_valid, busy} !== 3'b000) begin
        fails++; $display("FAIL empty_quiet got=%b exp=000", {fifo_rd_en, m_valid, busy});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_drain;
    int unsigned p0;
    int dcnt = 0;
    logic [7:0] dval = 8'h00;
    push_word(8'h21); push_word(8'h22); push_word(8'h23);
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL drain_first_pop got=%b exp=1", fifo_rd_en); end
    p0 = pop_cnt;
    @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (m_valid && m_ready) begin dcnt++; dval = m_data; end
      @(negedge clk);
    end
    checks++; if (pop_cnt - p0 != 1) begin fails++; $display("FAIL drain_pops got=%0d exp=1", pop_cnt - p0); end
    checks++; if (dcnt != 1) begin fails++; $display("FAIL drain_delivered got=%0d exp=1", dcnt); end
    checks++; if (dval !== 8'h21) begin fails++; $display("FAIL drain_data got=%h exp=21", dval); end
    checks++; if (dut.r_state !== IDLE) begin fails++; $display("FAIL drain_state got=%0d exp=%0d", dut.r_state, IDLE); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL drain_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int unsigned p0 = pop_cnt;
    int c = 0;
    push_word(8'h24);
    m_ready = 1'b0; enable = 1'b1;
    while (pop_cnt - p0 < 2 && c < 20) begin @(negedge clk); c++; end
    checks++; if (pop_cnt - p0 != 2) begin fails++; $display("FAIL rstmid_setup_pops got=%0d exp=2", pop_cnt - p0); end
    reset = 1'b1; fifo_flush = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got=%b exp=0", m_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    fifo_flush = 1'b0; reset = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale got=%b exp=0 data=%h", m_valid, m_data); end
      @(negedge clk);
    end
`ifdef FIFO_RD_STREAM_CNT_EN
    checks++; if (word_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_word_cnt got=%0d exp=0", word_cnt); end
`endif
  endtask

`ifdef FIFO_RD_STREAM_CNT_EN
  task automatic test_counter;
    cnt_clr = 1'b1; enable = 1'b1; m_ready = 1'b1;
    push_word(8'h31);
    repeat (6) @(negedge clk);
    checks++; if (word_cnt !== 16'd0) begin fails++; $display("FAIL cnt_clr_priority got=%0d exp=0", word_cnt); end
    cnt_clr = 1'b0;
    push_word(8'h32);
    repeat (6) @(negedge clk);
    checks++; if (word_cnt !== 16'd1) begin fails++; $display("FAIL cnt_after_clr got=%0d exp=1", word_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_empty();
    test_drain();
    test_reset_mid();
`ifdef FIFO_RD_STREAM_CNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_fifo_rd_stream
